// File: rtl/cpu_controller.sv
// Instruction sequencer for the register-file/shifter/ALU datapath.
// Latches one instruction on s, then steps the datapath strobes until it retires.
//
// state       | meaning
// ------------+-------------------------------------------------------------
// S_WAIT      | idle, w=1; IR captured from in when s=1
// S_DECODE    | classify IR; err pulse if the opcode/op pair is unsupported
// S_WRITE_IMM | write sign-extended imm8 into Rn
// S_GET_A     | read Rn into A
// S_GET_B     | read Rm into B
// S_COMPUTE   | shift/ALU, load C (or status for CMP)
// S_WRITE_REG | write C into Rd
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        s,
    input  logic [15:0] in,
    output logic        w,
    output logic        err,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        vsel,
    output logic        loada,
    output logic        loadb,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  shift,
    output logic [1:0]  ALUop,
    output logic        loadc,
    output logic        loads,
    output logic [15:0] datapath_in
);

    typedef enum logic [2:0] {
        S_WAIT,
        S_DECODE,
        S_WRITE_IMM,
        S_GET_A,
        S_GET_B,
        S_COMPUTE,
        S_WRITE_REG
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn;
    logic [2:0] rd;
    logic [1:0] sh;
    logic [2:0] rm;

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_cmp;
    logic is_mvn;
    logic supported;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign sh     = ir[4:3];
    assign rm     = ir[2:0];

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);
    assign supported  = is_mov_imm || is_mov_reg || is_alu;

    assign datapath_in = {{8{ir[7]}}, ir[7:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            if ((state == S_WAIT) && s) begin
                ir <= in;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT: begin
                if (s) state_next = S_DECODE;
            end
            S_DECODE: begin
                if (is_mov_imm)               state_next = S_WRITE_IMM;
                else if (is_mov_reg || is_mvn) state_next = S_GET_B;
                else if (is_alu)              state_next = S_GET_A;
                else                          state_next = S_WAIT;
            end
            S_WRITE_IMM: state_next = S_WAIT;
            S_GET_A:     state_next = S_GET_B;
            S_GET_B:     state_next = S_COMPUTE;
            S_COMPUTE:   state_next = is_cmp ? S_WAIT : S_WRITE_REG;
            S_WRITE_REG: state_next = S_WAIT;
            default:     state_next = S_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        err      = 1'b0;
        readnum  = 3'd0;
        writenum = 3'd0;
        write    = 1'b0;
        vsel     = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        shift    = 2'b00;
        ALUop    = 2'b00;
        loadc    = 1'b0;
        loads    = 1'b0;
        case (state)
            S_WAIT:   w = 1'b1;
            S_DECODE: err = ~supported;
            S_WRITE_IMM: begin
                writenum = rn;
                vsel     = 1'b1;
                write    = 1'b1;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            S_COMPUTE: begin
                shift = sh;
                asel  = is_mov_reg;
                ALUop = is_mov_reg ? 2'b00 : op;
                loads = is_cmp;
                loadc = ~is_cmp;
            end
            S_WRITE_REG: begin
                writenum = rd;
                write    = 1'b1;
            end
            default: w = 1'b0;
        endcase
        // Reset must never let a pending register write or load reach the datapath.
        if (reset) begin
            err   = 1'b0;
            write = 1'b0;
            loada = 1'b0;
            loadb = 1'b0;
            loadc = 1'b0;
            loads = 1'b0;
        end
    end

endmodule
